// File: rtl/fetch_stage_ctrl.sv
// Fetch-side PC register, F/D pipeline register and one-entry decode hold buffer.
// Define FETCH_PERF_CNT_EN to add saturating stall/flush event counters.
module fetch_stage_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PC_stall,
    input  logic            F_D_stall,
    input  logic            F_D_flush,
    input  logic            E_M_branch_taken,
    input  logic [XLEN-1:0] E_M_jb_target,
    output logic [XLEN-1:0] im_addr,
    input  logic [XLEN-1:0] im_rdata,
    output logic [XLEN-1:0] F_D_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic [XLEN-1:0] F_D_inst,
    output logic            F_D_valid
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fd_pc_q, fd_pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            held_q, held_d;

    // Redirect targets are word aligned; the low target bits are deliberately dropped.
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^E_M_jb_target[1:0];

    always_comb begin
        pc_d = pc_q + XLEN'(4);
        if (E_M_branch_taken) begin
            pc_d = {E_M_jb_target[XLEN-1:2], 2'b00};
        end else if (PC_stall) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        fd_pc_d = fd_pc_q;
        valid_d = valid_q;
        if (F_D_flush) begin
            fd_pc_d = pc_q;
            valid_d = 1'b0;
        end else if (!F_D_stall) begin
            fd_pc_d = pc_q;
            valid_d = 1'b1;
        end
    end

    // Capture the memory word on the first stalled edge; the memory moves on afterwards.
    always_comb begin
        hold_d = hold_q;
        held_d = 1'b0;
        if (F_D_stall && !F_D_flush) begin
            held_d = 1'b1;
            if (!held_q) begin
                hold_d = im_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            fd_pc_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            held_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fd_pc_q <= fd_pc_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            held_q  <= held_d;
        end
    end

    assign im_addr   = pc_q;
    assign F_D_pc    = fd_pc_q;
    assign F_D_valid = valid_q;
    assign F_D_inst  = !valid_q ? NOP_INST : (held_q ? hold_q : im_rdata);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (PC_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (F_D_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: two instances (RESET_PC 0 and 0xFFFF_FFF8)
// share stimulus; a transaction-level model predicts every cycle's decode slot.
module tb_fetch_stage_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PC_stall = 1'b0, F_D_stall = 1'b0, F_D_flush = 1'b0, E_M_branch_taken = 1'b0;
    logic [31:0] E_M_jb_target = '0;
    logic [31:0] im_addr0, im_rdata0 = '0, F_D_pc0, F_D_inst0;
    logic [31:0] im_addr1, im_rdata1 = '0, F_D_pc1, F_D_inst1;
    logic        F_D_valid0, F_D_valid1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
`endif

    always #5 clk = ~clk;

    fetch_stage_ctrl #(.XLEN(32), .RESET_PC(RPC0), .NOP_INST(NOP)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .PC_stall(PC_stall), .F_D_stall(F_D_stall),
        .F_D_flush(F_D_flush), .E_M_branch_taken(E_M_branch_taken),
        .E_M_jb_target(E_M_jb_target), .im_addr(im_addr0), .im_rdata(im_rdata0),
        .F_D_pc(F_D_pc0),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0),
`endif
        .F_D_inst(F_D_inst0), .F_D_valid(F_D_valid0)
    );

    fetch_stage_ctrl #(.XLEN(32), .RESET_PC(RPC1), .NOP_INST(NOP)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .PC_stall(PC_stall), .F_D_stall(F_D_stall),
        .F_D_flush(F_D_flush), .E_M_branch_taken(E_M_branch_taken),
        .E_M_jb_target(E_M_jb_target), .im_addr(im_addr1), .im_rdata(im_rdata1),
        .F_D_pc(F_D_pc1),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1),
`endif
        .F_D_inst(F_D_inst1), .F_D_valid(F_D_valid1)
    );

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        im_rdata0 <= mem_f(im_addr0);
        im_rdata1 <= mem_f(im_addr1);
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(F_D_stall && !PC_stall && !E_M_branch_taken))
            else $error("illegal combination: F_D_stall without PC_stall or branch");
        end
    end

    typedef struct packed {
        logic [31:0] addr0, fdpc0, inst0;
        logic        v0;
        logic [31:0] addr1, fdpc1, inst1;
        logic        v1;
        logic [31:0] scnt, fcnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    // Model: architectural PC, decode slot (pc, valid) and event counts per instance.
    logic [31:0] m_pc[2], m_fdpc[2];
    logic        m_val[2];
    logic [31:0] m_scnt = '0, m_fcnt = '0;
    logic [31:0] rpc[2] = '{RPC0, RPC1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_step(input logic r, ps, fs, fl, b, input logic [31:0] t);
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                m_pc[i] = rpc[i]; m_fdpc[i] = '0; m_val[i] = 1'b0;
            end else begin
                if (fl) begin
                    m_fdpc[i] = m_pc[i]; m_val[i] = 1'b0;
                end else if (!fs) begin
                    m_fdpc[i] = m_pc[i]; m_val[i] = 1'b1;
                end
                if (b) m_pc[i] = t & ~32'd3;
                else if (!ps) m_pc[i] = m_pc[i] + 32'd4;
            end
        end
        if (!r) begin
            m_scnt = '0; m_fcnt = '0;
        end else begin
            if (ps && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (fl && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        end
        e.addr0 = m_pc[0]; e.fdpc0 = m_fdpc[0]; e.v0 = m_val[0];
        e.inst0 = m_val[0] ? mem_f(m_fdpc[0]) : NOP;
        e.addr1 = m_pc[1]; e.fdpc1 = m_fdpc[1]; e.v1 = m_val[1];
        e.inst1 = m_val[1] ? mem_f(m_fdpc[1]) : NOP;
        e.scnt = m_scnt; e.fcnt = m_fcnt;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, ps, fs, fl, b, input logic [31:0] t);
        rst_n = r; PC_stall = ps; F_D_stall = fs; F_D_flush = fl;
        E_M_branch_taken = b; E_M_jb_target = t;
        @(posedge clk);
        model_step(r, ps, fs, fl, b, t);
        #1;
    endtask

    // Monitor: the decode slot is presented every cycle; compare it mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("im_addr0", im_addr0, e.addr0);
            check("F_D_pc0", F_D_pc0, e.fdpc0);
            check("F_D_valid0", {31'd0, F_D_valid0}, {31'd0, e.v0});
            check("F_D_inst0", F_D_inst0, e.inst0);
            check("im_addr1", im_addr1, e.addr1);
            check("F_D_pc1", F_D_pc1, e.fdpc1);
            check("F_D_valid1", {31'd0, F_D_valid1}, {31'd0, e.v1});
            check("F_D_inst1", F_D_inst1, e.inst1);
`ifdef FETCH_PERF_CNT_EN
            check("stall_cnt0", stall_cnt0, e.scnt);
            check("flush_cnt0", flush_cnt0, e.fcnt);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic b, fl, fs, ps, r;
        logic [31:0] t;

        // Reset, then free run (dut1 wraps through 0xFFFF_FFFC to 0).
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);

        // Three-cycle load-use stall with the 0x10 instruction in decode.
        n = 0;
        while (m_fdpc[0] != 32'h10 && n < 50) begin cyc(1, 0, 0, 0, 0, 0); n++; end
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);

        // Branch to 0x200 while the PC is at 0x40.
        n = 0;
        while (m_pc[0] != 32'h40 && n < 50) begin cyc(1, 0, 0, 0, 0, 0); n++; end
        cyc(1, 0, 0, 1, 1, 32'h200);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);

        // All hazard controls at once, unaligned target.
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 32'h0000_0333);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);

        // Reset in the middle of a stall.
        cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);

        // Five stall cycles and two flushes from a fresh reset.
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 32'h100);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

`ifdef FETCH_PERF_CNT_EN
        @(negedge clk);
        u_dut0.stall_cnt_q = 32'hFFFF_FFFF;
        m_scnt = 32'hFFFF_FFFF;
        #1;
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
`endif

        // Randomized legal hazard traffic.
        for (int i = 0; i < 400; i++) begin
            b  = ($urandom_range(0, 9) == 0);
            fl = b | ($urandom_range(0, 19) == 0);
            fs = ($urandom_range(0, 3) == 0);
            ps = fs | ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 59) != 0);
            t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            cyc(r, ps, fs, fl, b, t);
        end
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage_ctrl.md
# fetch_stage_ctrl

Fetch-side responder to the pipeline hazard controls. It owns the PC register and the F/D pipeline register and acts on `PC_stall`, `F_D_stall`, `F_D_flush` and `E_M_branch_taken`. It drives the synchronous instruction memory and uses a one-entry hold buffer so the instruction stays correct while decode is stalled. The block sits between the instruction memory and the decode stage.

## Interface
Parameters:
- `XLEN`, default 32: PC and instruction width.
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `NOP_INST`, default 32'h0000_0013: instruction presented to decode when F/D is invalid (`addi x0,x0,0`).

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `PC_stall`, input, 1: hold the PC.
- `F_D_stall`, input, 1: hold the F/D register.
- `F_D_flush`, input, 1: invalidate the F/D register.
- `E_M_branch_taken`, input, 1: redirect the PC.
- `E_M_jb_target`, input, XLEN: redirect target.
- `im_addr`, output, XLEN: instruction memory address. Equals `pc_q` (combinational).
- `im_rdata`, input, XLEN: instruction memory data for the address presented on the previous cycle.
- `F_D_pc`, output, XLEN: PC of the instruction in decode.
- `F_D_inst`, output, XLEN: instruction in decode.
- `F_D_valid`, output, 1: decode slot holds a real instruction.
- `stall_cnt`, output, 32: present only with `FETCH_PERF_CNT_EN`.
- `flush_cnt`, output, 32: present only with `FETCH_PERF_CNT_EN`.

## Operation
- **PC next-state**, in priority order:
  - `!rst_n` → `RESET_PC`.
  - `E_M_branch_taken` → `{E_M_jb_target[XLEN-1:2],2'b00}`. Branch overrides `PC_stall`.
  - `PC_stall` → hold.
  - Otherwise → `pc_q + 4`, wrapping modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- **F/D register** (`F_D_pc`, `valid_q`), in priority order:
  - Reset → `F_D_pc`=0, valid=0.
  - `F_D_flush` → `F_D_pc`<=`pc_q`, valid<=0. Flush wins over stall.
  - `F_D_stall` → hold.
  - Otherwise → `F_D_pc`<=`pc_q`, valid<=1.
- **Hold buffer** (`hold_q`, `held_q`):
  - On an edge with `F_D_stall=1`, `F_D_flush=0` and `held_q=0`: `hold_q`<=`im_rdata`, `held_q`<=1.
  - `held_q`<=0 on any edge with `F_D_stall=0`, on flush, or on reset.
  - While stall persists with `held_q=1`, `hold_q` is unchanged.
- **Decode output:** `F_D_inst` = `!valid_q` ? `NOP_INST` : (`held_q` ? `hold_q` : `im_rdata`). `F_D_valid` = `valid_q`.
- **Illegal combination** `F_D_stall=1` with `PC_stall=0` and no branch: the PC advances and F/D holds. The instruction at the skipped PC is lost. The bench flags this case with an assertion; RTL behaviour follows the priority rules above.
- **Reset during a stall:** all state is cleared, the PC returns to `RESET_PC`, and the hold buffer is discarded.

## Timing
- **Instruction latency:** address in cycle N → instruction in decode in cycle N+1. `F_D_pc` and `im_rdata` align with no extra delay.
- **Branch asserted in cycle N** (hazard unit raises `F_D_flush` in the same cycle):
  - N+1: `pc_q`=target, `F_D_valid`=0, `F_D_inst`=`NOP_INST`.
  - N+2: `F_D_pc`=target, valid=1, `F_D_inst`=inst(target).
- **Stall of k cycles starting in cycle N:** `F_D_pc` and `F_D_inst` are constant for cycles N..N+k. From N+1 on, `F_D_inst` comes from `hold_q`. `im_rdata` is ignored until the first cycle after release.
- **Reset values** (first cycle after `rst_n` rises): `pc_q`=`im_addr`=`RESET_PC`, `F_D_pc`=0, `F_D_valid`=0, `F_D_inst`=`NOP_INST`, `held_q`=0, counters=0.
- There are no combinational paths from `F_D_stall` or `F_D_flush` to `im_addr`.

## Configuration
- **`FETCH_PERF_CNT_EN` defined:**
  - `stall_cnt` increments on every edge with `PC_stall=1`.
  - `flush_cnt` increments on every edge with `F_D_flush=1`.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and are cleared by reset.
  - Counting is unaffected by branch priority.
- **Not defined:** the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- **Reset then free run:** `RESET_PC`=0. Two cycles after release, `F_D_pc`=0 with valid=1. `F_D_pc` then steps 4, 8, 12 on consecutive cycles, and `F_D_inst` matches memory at each PC.
- **Three-cycle load-use stall** with `F_D_pc`=0x10: `F_D_pc`=0x10 and `F_D_inst`=mem[0x10] across all four cycles. After release, 0x14 follows with mem[0x14]. No instruction is skipped or duplicated.
- **Branch to 0x200** while `pc_q`=0x40: the next cycle shows valid=0 and `F_D_inst`=0x0000_0013. The cycle after shows `F_D_pc`=0x200 with mem[0x200].
- **Branch + `PC_stall` + `F_D_stall` + `F_D_flush` in one cycle:** the PC goes to the target, F/D is invalidated, and `held_q`=0.
- **Reset mid-stall and PC wrap:** asserting reset mid-stall clears the hold buffer and the PC returns to `RESET_PC`. `RESET_PC`=0xFFFF_FFF8 with a free run gives `F_D_pc` = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **With `FETCH_PERF_CNT_EN`:** 5 stall cycles and 2 flushes give `stall_cnt`=5 and `flush_cnt`=2. A forced value of 0xFFFF_FFFF stays saturated.
